// File: rtl/modulo_demux36_1_seq_pkg.sv
// Shared constants and state encoding for the 1:36 serial demultiplexer.
// Optional build macro used by this slice: DEMUX_PARITY_EN.
package modulo_demux_pkg;

    localparam int N_CH     = 36;
    localparam int SEL_W    = 6;
    localparam int LAST_IDX = N_CH - 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Beat index k lands in frame bit N_CH-1-k, so the first serial bit is the MSB.
    function automatic logic [SEL_W-1:0] slot_of(input logic [SEL_W-1:0] idx);
        return SEL_W'(LAST_IDX) - idx;
    endfunction

endpackage

// File: rtl/modulo_demux36_1_seq_if.sv
// Serial-in / parallel-out bus of the 1:36 demultiplexer.
// parity_err exists only when DEMUX_PARITY_EN is defined.
interface modulo_demux36_1_seq_if;
    import modulo_demux_pkg::*;

    logic             start;
    logic             in_bit;
    logic             in_valid;
    logic             in_ready;
    logic [SEL_W-1:0] sel_out;
    logic             busy;
    logic [N_CH-1:0]  frame_q;
    logic             frame_valid;
`ifdef DEMUX_PARITY_EN
    logic             parity_err;
`endif

    modport slave (
        input  start, in_bit, in_valid,
        output in_ready, sel_out, busy, frame_q, frame_valid
`ifdef DEMUX_PARITY_EN
        , parity_err
`endif
    );

    modport master (
        output start, in_bit, in_valid,
        input  in_ready, sel_out, busy, frame_q, frame_valid
`ifdef DEMUX_PARITY_EN
        , parity_err
`endif
    );

endinterface

// File: rtl/modulo_demux36_1_seq_contador.sv
// Channel index counter: synchronous clear, count enable, wraps to 0 after LAST_IDX.
// tc flags the last channel so the FSM knows the current beat completes the frame.
module modulo_contador_sel6
    import modulo_demux_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [SEL_W-1:0] o_cnt,
    output logic             o_tc
);

    logic [SEL_W-1:0] r_cnt;

    assign o_tc  = (r_cnt == SEL_W'(LAST_IDX));
    assign o_cnt = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tc ? '0 : r_cnt + SEL_W'(1);
        end
    end

endmodule

// File: rtl/modulo_demux36_1_seq.sv
// Sequential 1:36 demultiplexer: shifts serial beats into a shadow frame and publishes
// it with a one-cycle strobe. DEMUX_PARITY_EN adds a trailing even-parity beat.
module modulo_demux36_1_seq
    import modulo_demux_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    modulo_demux36_1_seq_if.slave   bus
);

    state_t           r_state;
    state_t           w_next;
    logic             w_in_ready;
    logic             w_beat;
    logic             w_clr;
    logic             w_en;
    logic             w_tc;
    logic             w_load;
    logic [SEL_W-1:0] w_idx;
    logic [N_CH-1:0]  r_shadow;
    logic [N_CH-1:0]  w_shadow_nxt;
    logic [N_CH-1:0]  r_frame_q;
    logic             r_frame_valid;

    modulo_contador_sel6 u_contador (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_clr),
        .i_en  (w_en),
        .o_cnt (w_idx),
        .o_tc  (w_tc)
    );

    assign w_in_ready = (r_state == ST_SHIFT) || (r_state == ST_PARITY);
    assign w_beat     = bus.in_valid & w_in_ready;

    always_comb begin
        w_next = r_state;
        w_clr  = 1'b0;
        w_en   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_next = ST_SHIFT;
                    w_clr  = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (w_beat) begin
                    w_en = 1'b1;
                    if (w_tc) begin
`ifdef DEMUX_PARITY_EN
                        w_next = ST_PARITY;
`else
                        w_next = ST_DONE;
`endif
                    end
                end
            end
            ST_PARITY: begin
                if (w_beat) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // The frame is loaded on the edge that enters DONE so frame_q and the strobe rise together.
    always_comb begin
        w_shadow_nxt = r_shadow;
        if (w_clr) begin
            w_shadow_nxt = '0;
        end else if ((r_state == ST_SHIFT) && w_beat) begin
            w_shadow_nxt[slot_of(w_idx)] = bus.in_bit;
        end
    end

    assign w_load = (w_next == ST_DONE) && (r_state != ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_shadow      <= '0;
            r_frame_q     <= '0;
            r_frame_valid <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_shadow      <= w_shadow_nxt;
            r_frame_valid <= w_load;
            if (w_load) begin
                r_frame_q <= w_shadow_nxt;
            end
        end
    end

`ifdef DEMUX_PARITY_EN
    logic r_parity_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity_err <= 1'b0;
        end else if ((r_state == ST_PARITY) && w_beat) begin
            r_parity_err <= (^r_shadow) ^ bus.in_bit;
        end
    end

    assign bus.parity_err = r_parity_err;
`endif

    assign bus.in_ready    = w_in_ready;
    assign bus.sel_out     = w_idx;
    assign bus.busy        = (r_state != ST_IDLE);
    assign bus.frame_q     = r_frame_q;
    assign bus.frame_valid = r_frame_valid;

endmodule

// File: tb/tb_modulo_demux36_1_seq.sv
// Self-checking bench for modulo_demux36_1_seq: table vectors, hand sequences, random frames.
// Parity checks are compiled in when DEMUX_PARITY_EN is defined.
module tb_modulo_demux36_1_seq;
    import modulo_demux_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    modulo_demux36_1_seq_if bus ();

    modulo_demux36_1_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic [35:0] beats;
        logic [35:0] expFrame;
        int          gapMode;
    } vec_t;

    int          checks   = 0;
    int          failures = 0;
    logic [35:0] lastFrame = '0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Reference mapping: serial beat k is published at frame bit 35-k.
    function automatic logic [35:0] reverseFrame(input logic [35:0] b);
        logic [35:0] r;
        for (int k = 0; k < 36; k++) r[35-k] = b[k];
        return r;
    endfunction

    task automatic applyStimulus(input logic [35:0] beats, input int gapMode, input bit holdStart,
                                 input bit parityBit, input bit checkHold);
        int k;
        int guard;
        bit v;
        k = 0;
        guard = 0;
        if (!holdStart) begin
            bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
        end else begin
            bus.start = 1'b1;
        end
        while (k < 36 && guard < 400) begin
            case (gapMode)
                0:       v = 1'b1;
                1:       v = (guard % 2 == 0);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            bus.in_valid = v;
            bus.in_bit   = beats[k];
            checkOutput("selOut", 64'(bus.sel_out), 64'(k));
            checkOutput("inReady", 64'(bus.in_ready), 64'd1);
            checkOutput("noEarlyStrobe", 64'(bus.frame_valid), 64'd0);
            if (checkHold) checkOutput("frameHold", 64'(bus.frame_q), 64'(lastFrame));
            tick();
            if (v) k++;
            guard++;
        end
        if (k < 36) checkOutput("beatBudget", 64'(k), 64'd36);
`ifdef DEMUX_PARITY_EN
        bus.in_valid = 1'b0;
        checkOutput("parityNoStrobe", 64'(bus.frame_valid), 64'd0);
        checkOutput("parityReady", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.in_bit   = parityBit;
        tick();
`endif
        bus.in_valid = 1'b0;
        checkOutput("strobe", 64'(bus.frame_valid), 64'd1);
        checkOutput("frameQ", 64'(bus.frame_q), 64'(reverseFrame(beats)));
        checkOutput("doneReady", 64'(bus.in_ready), 64'd0);
        checkOutput("doneBusy", 64'(bus.busy), 64'd1);
`ifdef DEMUX_PARITY_EN
        checkOutput("parityErr", 64'(bus.parity_err), 64'((^beats) ^ parityBit));
`endif
        lastFrame = reverseFrame(beats);
    endtask

    task automatic idleAfter();
        tick();
        checkOutput("strobeOneCycle", 64'(bus.frame_valid), 64'd0);
        checkOutput("idleBusy", 64'(bus.busy), 64'd0);
        checkOutput("idleReady", 64'(bus.in_ready), 64'd0);
        checkOutput("idleFrameHold", 64'(bus.frame_q), 64'(lastFrame));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t        vecs[6];
        logic [35:0] beats;
        bit          p;

        vecs[0] = '{"alternate", 36'h5_5555_5555, 36'hA_AAAA_AAAA, 0};
        vecs[1] = '{"allOnes",   36'hF_FFFF_FFFF, 36'hF_FFFF_FFFF, 1};
        vecs[2] = '{"firstBeat", 36'h0_0000_0001, 36'h8_0000_0000, 1};
        vecs[3] = '{"zeros",     36'h0_0000_0000, 36'h0_0000_0000, 0};
        vecs[4] = '{"lastBeat",  36'h8_0000_0000, 36'h0_0000_0001, 0};
        vecs[5] = '{"lowNibble", 36'h0_0000_000F, 36'hF_0000_0000, 2};

        bus.start    = 1'b0;
        bus.in_bit   = 1'b0;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstBusy", 64'(bus.busy), 64'd0);
        checkOutput("rstReady", 64'(bus.in_ready), 64'd0);
        checkOutput("rstStrobe", 64'(bus.frame_valid), 64'd0);
        checkOutput("rstFrame", 64'(bus.frame_q), 64'd0);
        checkOutput("rstSel", 64'(bus.sel_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].beats, vecs[i].gapMode, 1'b0, ^vecs[i].beats, 1'b1);
            checkOutput({"table_", vecs[i].name}, 64'(bus.frame_q), 64'(vecs[i].expFrame));
            idleAfter();
        end

        // start held through SHIFT and DONE: ignored there, taken on the following IDLE cycle.
        bus.start = 1'b1;
        tick();
        applyStimulus(36'h0_F0F0_F0F0, 1, 1'b1, 1'b0, 1'b1);
        tick();
        checkOutput("heldStartIdle", 64'(bus.busy), 64'd0);
        checkOutput("heldStartStrobe", 64'(bus.frame_valid), 64'd0);
        checkOutput("heldStartFrame", 64'(bus.frame_q), 64'(lastFrame));
        tick();
        checkOutput("heldStartBusy", 64'(bus.busy), 64'd1);
        checkOutput("heldStartReady", 64'(bus.in_ready), 64'd1);
        applyStimulus(36'h9_1234_5678, 0, 1'b1, 1'b1, 1'b1);
        bus.start = 1'b0;
        idleAfter();

        // Asynchronous reset in the middle of a frame at channel 17.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 17; i++) begin
            bus.in_valid = 1'b1;
            bus.in_bit   = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        checkOutput("preResetSel", 64'(bus.sel_out), 64'd17);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncRstBusy", 64'(bus.busy), 64'd0);
        checkOutput("asyncRstSel", 64'(bus.sel_out), 64'd0);
        checkOutput("asyncRstFrame", 64'(bus.frame_q), 64'd0);
        checkOutput("asyncRstReady", 64'(bus.in_ready), 64'd0);
        checkOutput("asyncRstStrobe", 64'(bus.frame_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        lastFrame = '0;
        tick();
        checkOutput("postRstBusy", 64'(bus.busy), 64'd0);

`ifdef DEMUX_PARITY_EN
        applyStimulus(36'h0_0000_0007, 0, 1'b0, 1'b1, 1'b1);
        checkOutput("parityGood", 64'(bus.parity_err), 64'd0);
        idleAfter();
        checkOutput("parityGoodHeld", 64'(bus.parity_err), 64'd0);
        applyStimulus(36'h0_0000_0007, 0, 1'b0, 1'b0, 1'b1);
        checkOutput("parityBad", 64'(bus.parity_err), 64'd1);
        idleAfter();
        checkOutput("parityBadHeld", 64'(bus.parity_err), 64'd1);
`endif

        for (int n = 0; n < 20; n++) begin
            beats = {4'($urandom_range(0, 15)), 32'($urandom())};
            p     = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 2)) tick();
            applyStimulus(beats, 2, 1'b0, p, 1'b1);
            idleAfter();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
